// File: rtl/tdsp_pkg.sv
// ---------------------------------------------------------------------------
// tdsp_pkg
// Shared TDSP definitions: default data and address widths for the data
// responder, and the arbiter state encoding used by tdsp_bus_arb.
// ---------------------------------------------------------------------------
package tdsp_pkg;

  localparam int TDSP_DATA_W = 16;
  localparam int TDSP_ADDR_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CORE = 2'd1,
    ARB_EXT  = 2'd2,
    ARB_TURN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/tdsp_bus_arb.sv
// ---------------------------------------------------------------------------
// tdsp_bus_arb
// Two-master bus arbiter (core and external master) with a one-cycle
// turnaround between owners. The core wins a simultaneous request and keeps
// the bus for as long as write_h_i is held.
//
// Ports
//   clk            system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   bus_request_i  core bus request
//   ext_req_i      external master request
//   write_h_i      core write hold (pins the core grant)
//   bus_grant_o    registered grant to the core
//   ext_gnt_o      registered grant to the external master
// ---------------------------------------------------------------------------
module tdsp_bus_arb
  import tdsp_pkg::*;
(
  input  logic clk,
  input  logic rst_ni,
  input  logic bus_request_i,
  input  logic ext_req_i,
  input  logic write_h_i,
  output logic bus_grant_o,
  output logic ext_gnt_o
);

  arb_state_e state_q, state_d;
  logic       armed_q;
  logic       bus_grant_q;
  logic       ext_gnt_q;

  // armed_q holds off requests for the first edge after reset release, so the
  // earliest possible grant lands on the second rising edge.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      armed_q     <= 1'b0;
      bus_grant_q <= 1'b0;
      ext_gnt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= 1'b1;
      bus_grant_q <= (state_d == ARB_CORE);
      ext_gnt_q   <= (state_d == ARB_EXT);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (armed_q) begin
          if (bus_request_i) begin
            state_d = ARB_CORE;
          end else if (ext_req_i) begin
            state_d = ARB_EXT;
          end
        end
      end
      ARB_CORE: begin
        if (!write_h_i && !bus_request_i) begin
          state_d = ARB_TURN;
        end
      end
      ARB_EXT: begin
        if (!ext_req_i) begin
          state_d = ARB_TURN;
        end
      end
      ARB_TURN: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  assign bus_grant_o = bus_grant_q;
  assign ext_gnt_o   = ext_gnt_q;

endmodule

// File: rtl/tdsp_data_resp.sv
// ---------------------------------------------------------------------------
// tdsp_data_resp
// Data-side responder for the TDSP core: a scratch store mapped at address 0
// upward, access decode/validation, and the bus arbiter between the core and
// an external master.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   as           core data address strobe
//   read, write  core read / write enables (exactly one per valid access)
//   write_h      core write hold, keeps the core grant
//   address      core data address
//   t_data_out   core write data
//   t_data_in    registered read data to the core
//   bus_request  core bus request
//   bus_grant    registered grant to the core
//   ext_req      external master request
//   ext_gnt      registered grant to the external master
//   err          one-cycle pulse for a rejected core access
// ---------------------------------------------------------------------------
module tdsp_data_resp
  import tdsp_pkg::*;
#(
  parameter int DATA_W    = TDSP_DATA_W,
  parameter int ADDR_W    = TDSP_ADDR_W,
  parameter int MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              as,
  input  logic              read,
  input  logic              write,
  input  logic              write_h,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] t_data_out,
  output logic [DATA_W-1:0] t_data_in,
  input  logic              bus_request,
  output logic              bus_grant,
  input  logic              ext_req,
  output logic              ext_gnt,
  output logic              err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);

  logic              core_gnt;
  logic              in_range;
  logic              one_op;
  logic              acc_ok;
  logic              acc_rej;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] t_data_in_q;
  logic              err_q;

  tdsp_bus_arb u_arb (
    .clk           (clk),
    .rst_ni        (reset),
    .bus_request_i (bus_request),
    .ext_req_i     (ext_req),
    .write_h_i     (write_h),
    .bus_grant_o   (core_gnt),
    .ext_gnt_o     (ext_gnt)
  );

  // Range check is done on the full address; the store index is only the
  // low bits, so out-of-range addresses must never reach the array.
  assign in_range = ({1'b0, address} < DEPTH_C);
  assign one_op   = read ^ write;
  assign acc_ok   = as & core_gnt & one_op & in_range;
  assign acc_rej  = as & ~acc_ok;
  assign idx      = address[IDX_W-1:0];

  // Store is not reset: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (acc_ok && write) begin
      mem_q[idx] <= t_data_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_data_in_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= acc_rej;
      if (acc_ok && read) begin
        t_data_in_q <= mem_q[idx];
      end else if (acc_rej && read) begin
        // A refused read returns zero rather than stale data.
        t_data_in_q <= '0;
      end
    end
  end

  assign t_data_in = t_data_in_q;
  assign err       = err_q;
  assign bus_grant = core_gnt;

endmodule

// File: tb/tb_tdsp_data_resp.sv
module tb_tdsp_data_resp;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 64;

  logic          clk;
  logic          reset;
  logic          as;
  logic          read;
  logic          write;
  logic          write_h;
  logic [AW-1:0] address;
  logic [DW-1:0] t_data_out;
  logic [DW-1:0] t_data_in;
  logic          bus_request;
  logic          bus_grant;
  logic          ext_req;
  logic          ext_gnt;
  logic          err;

  tdsp_data_resp #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .as          (as),
    .read        (read),
    .write       (write),
    .write_h     (write_h),
    .address     (address),
    .t_data_out  (t_data_out),
    .t_data_in   (t_data_in),
    .bus_request (bus_request),
    .bus_grant   (bus_grant),
    .ext_req     (ext_req),
    .ext_gnt     (ext_gnt),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int            due;
    bit            bg;
    bit            eg;
    bit            err;
    bit            chk_data;
    logic [DW-1:0] data;
    string         tag;
  } exp_t;

  exp_t sb[$];

  // Behavioural reference: word store, last returned data, current grant.
  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] mdl_rd;
  bit            rd_known;
  bit            cur_bg;

  // One call = one clock cycle of stimulus. Expected outputs after the next
  // rising edge are pushed to the scoreboard.
  task automatic drive(input bit a, input bit r, input bit w, input bit wh,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d,
                       input bit breq, input bit ereq,
                       input bit bg_e, input bit eg_e, input string tag);
    exp_t e;
    as = a; read = r; write = w; write_h = wh; address = ad;
    t_data_out = d; bus_request = breq; ext_req = ereq;
    e.due = cyc + 1; e.bg = bg_e; e.eg = eg_e; e.tag = tag; e.err = 1'b0;
    if (a && reset) begin
      if (cur_bg && (r != w) && (int'(ad) < DEPTH)) begin
        if (w) mdl_mem[int'(ad)] = d;
        else begin
          mdl_rd   = mdl_mem[int'(ad)];
          rd_known = 1'b1;
        end
      end else begin
        e.err = 1'b1;
        if (r && w) rd_known = 1'b0;
        else if (r) begin
          mdl_rd   = '0;
          rd_known = 1'b1;
        end
      end
    end
    e.data = mdl_rd;
    e.chk_data = rd_known;
    sb.push_back(e);
    cur_bg = bg_e;
    @(negedge clk);
  endtask

  // Monitor: compares every entry whose edge has passed.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      vectors++;
      if (bus_grant !== e.bg) begin
        miscompares++;
        $display("FAIL %s bus_grant got %0b expected %0b", e.tag, bus_grant, e.bg);
      end
      vectors++;
      if (ext_gnt !== e.eg) begin
        miscompares++;
        $display("FAIL %s ext_gnt got %0b expected %0b", e.tag, ext_gnt, e.eg);
      end
      vectors++;
      if (err !== e.err) begin
        miscompares++;
        $display("FAIL %s err got %0b expected %0b", e.tag, err, e.err);
      end
      if (e.chk_data) begin
        vectors++;
        if (t_data_in !== e.data) begin
          miscompares++;
          $display("FAIL %s t_data_in got %h expected %h", e.tag, t_data_in, e.data);
        end
      end
      $display("txn cyc=%0d %s bg=%0b eg=%0b err=%0b data=%h", cyc, e.tag,
               bus_grant, ext_gnt, err, t_data_in);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    as = 0; read = 0; write = 0; write_h = 0; address = '0; t_data_out = '0;
    bus_request = 0; ext_req = 0; reset = 1'b0;
    mdl_rd = '0; rd_known = 1'b1; cur_bg = 1'b0;

    // Reset held: everything low, requests asserted must be ignored.
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 0, 0, "rst_hold");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 0, 0, "rst_hold");

    // Release with bus_request already high: grant on the second edge.
    #2 reset = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 0, "rel_e1");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 1, 0, "rel_e2");

    // Fill the store so every later read has a known value.
    for (int i = 0; i < DEPTH; i++)
      drive(1, 0, 1, 0, AW'(i), DW'($urandom), 1, 0, 1, 0, "fill");

    // Write then read back on the next cycle.
    drive(1, 0, 1, 0, 8'h05, 16'h1234, 1, 0, 1, 0, "wr05");
    drive(1, 1, 0, 0, 8'h05, 16'h0, 1, 0, 1, 0, "rd05");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 1, 0, "hold05");

    // Out-of-range read/write (0x40 aliases word 0 if range is ignored).
    drive(1, 1, 0, 0, 8'h40, 16'h0, 1, 0, 1, 0, "rd40");
    drive(1, 0, 1, 0, 8'h40, 16'hdead, 1, 0, 1, 0, "wr40");
    drive(1, 0, 1, 0, 8'hff, 16'hbeef, 1, 0, 1, 0, "wrff");
    drive(1, 1, 0, 0, 8'h00, 16'h0, 1, 0, 1, 0, "rd00");
    drive(1, 1, 0, 0, 8'h3f, 16'h0, 1, 0, 1, 0, "rd3f");
    drive(1, 0, 0, 0, 8'h01, 16'h0, 1, 0, 1, 0, "noop");
    drive(1, 1, 1, 0, 8'h02, 16'h5555, 1, 0, 1, 0, "both");
    drive(1, 1, 0, 0, 8'h02, 16'h0, 1, 0, 1, 0, "rd02");
    drive(0, 1, 1, 0, 8'h90, 16'h7777, 1, 0, 1, 0, "as0");

    // Random accesses with the core grant held.
    for (int i = 0; i < 300; i++) begin
      int unsigned op;
      bit r, w;
      op = $urandom_range(0, 7);
      r = (op == 1) || (op >= 2 && op <= 4);
      w = (op == 1) || (op >= 5);
      drive(bit'($urandom_range(0, 3) != 0), r, w, bit'($urandom_range(0, 1)),
            AW'($urandom_range(0, 79)), DW'($urandom), 1, 0, 1, 0, "rand");
    end

    // Write hold keeps the core grant after bus_request drops.
    drive(0, 0, 0, 1, 8'h00, 16'h0, 0, 0, 1, 0, "wh1");
    drive(0, 0, 0, 1, 8'h00, 16'h0, 0, 0, 1, 0, "wh2");
    drive(0, 0, 0, 1, 8'h00, 16'h0, 0, 0, 1, 0, "wh3");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 0, "turn");
    drive(1, 1, 0, 0, 8'h05, 16'h0, 0, 0, 0, 0, "rd_nogrant");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 0, "idle");

    // Simultaneous requests: core first, then external after TURN and IDLE.
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 1, 0, "both_req");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 1, 0, "core_hold");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 0, 1, 0, 0, "turn2");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 0, 1, 0, 0, "idle2");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 0, 1, 0, 1, "ext_gnt");
    drive(1, 0, 1, 0, 8'h05, 16'hface, 0, 1, 0, 1, "ext_hold_wr");
    drive(1, 1, 0, 0, 8'h05, 16'h0, 0, 0, 0, 0, "turn3_rd");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 0, "idle3");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 1, 0, "regrant");

    // Reset pulse mid-grant: grant drops without a clock edge.
    #2 reset = 1'b0;
    write_h = 1'b1;
    bus_request = 1'b0;
    #1;
    vectors++;
    if (bus_grant !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst bus_grant got %0b expected 0", bus_grant);
    end
    vectors++;
    if (t_data_in !== '0) begin
      miscompares++;
      $display("FAIL async_rst t_data_in got %h expected 0000", t_data_in);
    end
    mdl_rd = '0; rd_known = 1'b1; cur_bg = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    // Held write_h from before the reset must not revive the core grant.
    drive(0, 0, 0, 1, 8'h00, 16'h0, 0, 0, 0, 0, "post_rst_wh");
    drive(0, 0, 0, 1, 8'h00, 16'h0, 0, 0, 0, 0, "post_rst_wh");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 1, 0, "post_rst_gnt");
    drive(1, 1, 0, 0, 8'h05, 16'h0, 1, 0, 1, 0, "post_rst_rd05");
    drive(0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 1, 0, "tail");
    @(negedge clk);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdsp_data_resp.md
TDSP_DATA_RESP -- requirements
Module: tdsp_data_resp

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data bus width in bits.
REQ-002 Parameter ADDR_W, default 8, SHALL set the data address width in bits.
REQ-003 Parameter MEM_DEPTH, default 64, SHALL set the number of words in the scratch store, mapped at address 0 upward.
REQ-004 clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 as  input  1  SHALL be the core data address strobe.
REQ-007 read  input  1  SHALL be the core read enable.
REQ-008 write  input  1  SHALL be the core write enable.
REQ-009 write_h  input  1  SHALL be the core write hold.
REQ-010 address  input  ADDR_W  SHALL be the core data address.
REQ-011 t_data_out  input  DATA_W  SHALL be the core write data.
REQ-012 t_data_in  output  DATA_W  SHALL be the registered read data returned to the core.
REQ-013 bus_request  input  1  SHALL be the core bus request.
REQ-014 bus_grant  output  1  SHALL be the registered grant to the core.
REQ-015 ext_req  input  1  SHALL be the external master request.
REQ-016 ext_gnt  output  1  SHALL be the registered grant to the external master.
REQ-017 err  output  1  SHALL be a one-cycle pulse flagging a rejected core access.

Function
REQ-018 Arbiter states SHALL be IDLE, CORE, EXT and TURN; at most one of bus_grant and ext_gnt SHALL be high in any cycle.
REQ-019 IDLE: bus_request=1 SHALL go to CORE; otherwise ext_req=1 SHALL go to EXT; if both are 1, the core SHALL win.
REQ-020 bus_grant SHALL be 1 exactly when the state is CORE, first rising one cycle after bus_request is sampled high in IDLE.
REQ-021 CORE: when bus_request=0 and write_h=0, the arbiter SHALL go to TURN; while write_h=1 it SHALL remain in CORE regardless of bus_request.
REQ-022 EXT: when ext_req=0, the arbiter SHALL go to TURN; ext_gnt SHALL be 1 exactly when the state is EXT.
REQ-023 TURN SHALL last exactly one cycle with no grant, then go to IDLE.
REQ-024 An access SHALL be valid when as=1, bus_grant=1, exactly one of read/write is 1, and address < MEM_DEPTH.
REQ-025 Valid read sampled at edge k: t_data_in SHALL equal mem[address] from edge k+1 and hold until the next valid read.
REQ-026 Valid write sampled at edge k: mem[address] SHALL be updated with t_data_out at edge k.
REQ-027 A read at edge k+1 to an address written at edge k SHALL return the new data.
REQ-028 Rejected access: as=1 with any of bus_grant=0, read=write=1, read=write=0, or address >= MEM_DEPTH.
REQ-029 On a rejected access, err SHALL pulse high for one cycle (edge k+1), memory SHALL be unchanged, and t_data_in SHALL be 0 for a rejected read, else unchanged.
REQ-030 With as=0, read, write and address SHALL be ignored.

Reset
REQ-031 While reset=0: state=IDLE, bus_grant=0, ext_gnt=0, err=0, t_data_in=0.
REQ-032 Memory contents SHALL be unchanged by reset; an in-flight write hold SHALL be abandoned.
REQ-033 After release, the first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-034 Arbiter state encoding, DATA_W and ADDR_W defaults SHALL live in the shared tdsp definitions header.
REQ-035 The arbiter SHALL be a sub-module named tdsp_bus_arb; the memory and decode SHALL stay in tdsp_data_resp.

Verification
REQ-036 Reset release, bus_request=1 from cycle 0: bus_grant=1 at cycle 2, ext_gnt=0 throughout.
REQ-037 Granted write 0x1234 to address 0x05, then read 0x05 next cycle: t_data_in=0x1234 one cycle after the read, err=0.
REQ-038 Read address 0x40 with the grant held: t_data_in=0x0000, one err pulse, memory unchanged.
REQ-039 bus_request falls while write_h=1 for 3 cycles: bus_grant stays 1 until write_h=0, then TURN for one cycle, then IDLE.
REQ-040 bus_request and ext_req rise together in IDLE: core granted first; after bus_request drops, TURN, IDLE, then ext_gnt=1.
REQ-041 reset=0 pulsed mid-grant: bus_grant falls asynchronously; mem[0x05] still reads 0x1234 after re-grant.
